// File: rtl/forward_ctrl.sv
// Sequencing controller for the forward datapath: loads the parameter bank, collects one
// 3x3 sample frame, starts the datapath, waits out its latency and holds the result.
module forward_ctrl #(
    parameter int DW      = 16,
    parameter int NPRM    = 67,
    parameter int NX      = 9,
    parameter int LATENCY = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_reload,
    input  logic               prm_valid,
    output logic               prm_ready,
    input  logic [DW-1:0]      prm_data,
    input  logic               x_valid,
    output logic               x_ready,
    input  logic [DW-1:0]      x_data,
    output logic [NPRM*DW-1:0] param_bus,
    output logic [NX*DW-1:0]   x_bus,
    output logic               dp_start,
    input  logic [NX*DW-1:0]   dp_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [NX*DW-1:0]   res_data,
    output logic               busy
);

    localparam int PCW = (NPRM > 1) ? $clog2(NPRM) : 1;
    localparam int XCW = (NX > 1) ? $clog2(NX) : 1;
    localparam int WCW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_PRM,
        ST_LOAD_X,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [PCW-1:0] pcnt;
    logic [XCW-1:0] xcnt;
    logic [WCW-1:0] wcnt;
    logic           reload_pend;

    logic prm_fire;
    logic x_fire;
    logic res_fire;
    logic prm_last;
    logic x_last;
    logic wait_done;

    assign prm_fire = prm_valid && prm_ready;
    assign x_fire   = x_valid && x_ready;
    assign res_fire = res_valid && res_ready;
    assign prm_last = prm_fire && (pcnt == PCW'(NPRM - 1));
    assign x_last   = x_fire && (xcnt == XCW'(NX - 1));

    // The counter is frozen during the dp_start cycle so the capture lands LATENCY cycles
    // after the start pulse, i.e. LATENCY+1 edges after the final sample transfer.
    assign wait_done = (state == ST_WAIT) && !dp_start && (wcnt == WCW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     state_nxt = ST_LOAD_PRM;
            ST_LOAD_PRM: if (prm_last) state_nxt = ST_LOAD_X;
            ST_LOAD_X:   if (x_last) state_nxt = ST_WAIT;
            ST_WAIT:     if (wait_done) state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (res_fire) begin
                    state_nxt = reload_pend ? ST_LOAD_PRM : ST_LOAD_X;
                end
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        prm_ready = 1'b0;
        x_ready   = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE:     busy      = 1'b0;
            ST_LOAD_PRM: prm_ready = 1'b1;
            ST_LOAD_X:   x_ready   = 1'b1;
            ST_WAIT:     busy      = 1'b1;
            ST_HOLD: begin
                res_valid = 1'b1;
                busy      = 1'b0;
            end
            default:     busy      = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt     <= '0;
            xcnt     <= '0;
            wcnt     <= '0;
            dp_start <= 1'b0;
        end else begin
            dp_start <= x_last;
            if (prm_fire) begin
                pcnt <= prm_last ? '0 : pcnt + PCW'(1);
            end
            if (x_fire) begin
                xcnt <= x_last ? '0 : xcnt + XCW'(1);
            end
            if (x_last) begin
                wcnt <= WCW'(LATENCY);
            end else if (state == ST_WAIT && !dp_start && wcnt != '0) begin
                wcnt <= wcnt - WCW'(1);
            end
        end
    end

    // A request arriving on the very cycle we enter the load must survive the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_pend <= 1'b0;
        end else if (cfg_reload) begin
            reload_pend <= 1'b1;
        end else if (state != ST_LOAD_PRM && state_nxt == ST_LOAD_PRM) begin
            reload_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            param_bus <= '0;
            x_bus     <= '0;
            res_data  <= '0;
        end else begin
            if (prm_fire) begin
                param_bus[int'(pcnt)*DW +: DW] <= prm_data;
            end
            if (x_fire) begin
                x_bus[int'(xcnt)*DW +: DW] <= x_data;
            end
            if (wait_done) begin
                res_data <= dp_out;
            end
        end
    end

endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 Parameter DW, default 16, meaning Q8.8 word width of every parameter, sample and result word.
REQ-002 Parameter NPRM, default 67, meaning parameter words per load (36 conv weights, 18 dense weights, 4 b2 biases, 9 b3 biases).
REQ-003 Parameter NX, default 9, meaning input sample words per frame (3x3 patch).
REQ-004 Parameter LATENCY, default 8, meaning cycles from dp_start to datapath outputs being valid (range 1..255).
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 cfg_reload  input  1  one-cycle request to reload all parameters after the current frame.
REQ-008 prm_valid, prm_ready, prm_data  input/output/input  1/1/DW  parameter stream.
REQ-009 x_valid, x_ready, x_data  input/output/input  1/1/DW  sample stream.
REQ-010 param_bus  output  NPRM*DW  parameter bank to the forward datapath; word i at bits [i*DW+DW-1 : i*DW].
REQ-011 x_bus  output  NX*DW  sample bank to the datapath; word i is x(i+1).
REQ-012 dp_start  output  1  one-cycle pulse marking the start of a datapath evaluation.
REQ-013 dp_out  input  NX*DW  datapath outputs out1..out9.
REQ-014 res_valid, res_ready, res_data  output/input/output  1/1/NX*DW  result handshake.
REQ-015 busy  output  1  high in every state except ST_IDLE and ST_HOLD.

Function
REQ-016 States SHALL be ST_IDLE, ST_LOAD_PRM, ST_LOAD_X, ST_WAIT, ST_HOLD; encoding is free.
REQ-017 ST_IDLE -> ST_LOAD_PRM unconditionally on the first edge after reset release.
REQ-018 prm_ready SHALL be 1 only in ST_LOAD_PRM; x_ready SHALL be 1 only in ST_LOAD_X; both are 0 in all other states.
REQ-019 Transfer occurs only on valid&&ready at the clock edge; valid without ready SHALL have no effect.
REQ-020 In ST_LOAD_PRM each transfer writes prm_data to param word pcnt, then pcnt increments; pcnt starts at 0.
REQ-021 Word order: wc1(1..9), wd1(1..9), wc2(1..9), wd2(1..9), w11,w12..w91,w92, b21..b24, b31..b39.
REQ-022 On the transfer with pcnt==NPRM-1: pcnt clears to 0, state -> ST_LOAD_X.
REQ-023 In ST_LOAD_X each transfer writes x_data to x word xcnt; on xcnt==NX-1: xcnt clears, dp_start=1 for the next cycle only, wait counter loads LATENCY, state -> ST_WAIT.
REQ-024 In ST_WAIT the counter decrements by 1 per cycle; on the cycle it reads 1, dp_out SHALL be registered into res_data and state -> ST_HOLD, so res_valid rises exactly LATENCY+1 cycles after the final x transfer edge.
REQ-025 res_valid SHALL be 1 exactly in ST_HOLD; res_data SHALL stay stable while res_valid=1.
REQ-026 On res_valid&&res_ready: state -> ST_LOAD_PRM if reload_pend=1, else ST_LOAD_X; res_valid falls on that edge.
REQ-027 reload_pend sets on cfg_reload in any state; it clears on entry to ST_LOAD_PRM; cfg_reload on the same cycle as entry SHALL leave it set.
REQ-028 param_bus SHALL change only by ST_LOAD_PRM transfers; x_bus only by ST_LOAD_X transfers; both hold their values otherwise.
REQ-029 No arithmetic is performed on data words; they pass bit-exact (signed Q8.8).

Reset
REQ-030 On rst=0, immediately and regardless of clk: state=ST_IDLE, pcnt=xcnt=0, wait counter=0, reload_pend=0, param_bus=0, x_bus=0, res_data=0.
REQ-031 During and after reset, until leaving ST_IDLE: prm_ready=x_ready=dp_start=res_valid=busy=0.
REQ-032 Reset asserted mid-load or mid-wait SHALL abandon the operation; after release, a full parameter reload is required.

Verification
REQ-033 Stream 67 words with values 0x0001..0x0043, then x = 0100,0000,0100,... -> param word i = i+1, x_bus matches, dp_start pulses once, res_valid rises 9 cycles after the last x edge (LATENCY=8).
REQ-034 Toggle prm_valid every other cycle during the load -> still exactly 67 words captured, no word skipped or duplicated.
REQ-035 Hold res_ready=0 for 20 cycles in ST_HOLD -> res_valid stays 1, res_data unchanged, x_ready=0; x_valid ignored.
REQ-036 Pulse cfg_reload during ST_WAIT -> after the result handshake the state enters ST_LOAD_PRM; without the pulse it returns to ST_LOAD_X, param_bus unchanged.
REQ-037 Drop rst after 30 parameter words -> all outputs zero asynchronously; after release a fresh 67-word load is required before any result appears.
REQ-038 Back-to-back frames with res_ready=1 and x_valid=1 -> one result per NX+LATENCY+2 cycles.
